grf_wb_arbiter: RTL and testbench

- Writer side of the general register file's single write port: merges writebacks from the in-order pipeline (W stage) and a long-latency unit (divider, load-miss return) onto one WE3/A3/WD3/PC stream.
- Long-latency results are buffered in a small FIFO and drain only on cycles the pipeline does not write.
- Maintains a per-register pending scoreboard for the hazard unit and requests a pipeline bubble when buffered results starve.

---
 rtl/grf_wb_arbiter_pkg.sv | 21 ++
 rtl/grf_wb_arbiter_fifo.sv | 72 +++++++
 rtl/grf_wb_arbiter.sv | 135 +++++++++++++
 tb/tb_grf_wb_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/grf_wb_arbiter_pkg.sv
// ============================================================================
// grf_wb_arbiter_pkg : shared widths and writeback entry type for the GRF
//                      write-port arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package grf_wb_arbiter_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] pc;
    } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/grf_wb_arbiter_fifo.sv
// ============================================================================
// grf_wb_fifo : DEPTH-entry synchronous FIFO of writeback entries, no
//               fall-through; reports full/empty/occupancy.
// Revision: 1.0
// ============================================================================
`default_nettype none

module grf_wb_fifo
    import grf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  wb_entry_t                wr_entry,
    output wb_entry_t                rd_entry,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign full     = (r_count == CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign rd_entry = r_mem[r_rd_ptr];

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/grf_wb_arbiter.sv
// ============================================================================
// grf_wb_arbiter : merges pipeline and long-latency writebacks onto the single
//                  GRF write port, with pending scoreboard and starvation stall.
// Revision: 1.0
// ============================================================================
`default_nettype none

module grf_wb_arbiter
    import grf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     p_we,
    input  logic [REG_W-1:0]         p_addr,
    input  logic [DATA_W-1:0]        p_data,
    input  logic [DATA_W-1:0]        p_pc,
    input  logic                     l_valid,
    output logic                     l_ready,
    input  logic [REG_W-1:0]         l_addr,
    input  logic [DATA_W-1:0]        l_data,
    input  logic [DATA_W-1:0]        l_pc,
    input  logic                     iss_valid,
    input  logic [REG_W-1:0]         iss_dst,
    output logic                     we3,
    output logic [REG_W-1:0]         a3,
    output logic [DATA_W-1:0]        wd3,
    output logic [DATA_W-1:0]        pc_out,
    output logic [31:0]              pending,
    output logic                     stall_req,
    output logic                     waw_err,
    output logic [$clog2(DEPTH):0]   fifo_cnt
);

    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    wb_entry_t         w_wr_entry;
    wb_entry_t         w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [31:0]       w_pend_nxt;
    logic [WAIT_W-1:0] w_wait_nxt;

    logic [31:0]       r_pending;
    logic [WAIT_W-1:0] r_wait;
    logic              r_stall;
    logic              r_waw;

    assign w_wr_entry = '{addr: l_addr, data: l_data, pc: l_pc};

    // Readiness is gated by reset so nothing is handed over while held.
    assign l_ready = reset && !w_full;
    assign w_push  = l_valid && l_ready && (l_addr != '0);
    assign w_pop   = reset && !p_we && !w_empty;

    grf_wb_fifo #(
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (w_push),
        .pop      (w_pop),
        .wr_entry (w_wr_entry),
        .rd_entry (w_head),
        .full     (w_full),
        .empty    (w_empty),
        .count    (fifo_cnt)
    );

    always_comb begin
        we3    = 1'b0;
        a3     = '0;
        wd3    = '0;
        pc_out = '0;
        if (reset) begin
            if (p_we) begin
                we3    = 1'b1;
                a3     = p_addr;
                wd3    = p_data;
                pc_out = p_pc;
            end else if (!w_empty) begin
                we3    = 1'b1;
                a3     = w_head.addr;
                wd3    = w_head.data;
                pc_out = w_head.pc;
            end
        end
    end

    // Clear first so a same-cycle issue to the same register wins.
    always_comb begin
        w_pend_nxt = r_pending;
        if (w_pop) begin
            w_pend_nxt[w_head.addr] = 1'b0;
        end
        if (iss_valid && (iss_dst != '0)) begin
            w_pend_nxt[iss_dst] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_comb begin
        w_wait_nxt = r_wait;
        if (w_empty || w_pop) begin
            w_wait_nxt = '0;
        end else if (p_we && (r_wait != WAIT_W'(STARVE_LIMIT))) begin
            w_wait_nxt = r_wait + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending <= '0;
            r_wait    <= '0;
            r_stall   <= 1'b0;
            r_waw     <= 1'b0;
        end else begin
            r_pending <= w_pend_nxt;
            r_wait    <= w_wait_nxt;
            r_stall   <= (w_wait_nxt == WAIT_W'(STARVE_LIMIT));
            r_waw     <= p_we && (p_addr != '0) && r_pending[p_addr];
        end
    end

    assign pending   = r_pending;
    assign stall_req = r_stall;
    assign waw_err   = r_waw;

endmodule

`default_nettype wire

// File: tb/tb_grf_wb_arbiter.sv
// ============================================================================
// tb_grf_wb_arbiter : directed self-checking bench for grf_wb_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_grf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_we;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    logic [31:0] p_pc;
    logic        l_valid;
    logic        l_ready;
    logic [4:0]  l_addr;
    logic [31:0] l_data;
    logic [31:0] l_pc;
    logic        iss_valid;
    logic [4:0]  iss_dst;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [31:0] pc_out;
    logic [31:0] pending;
    logic        stall_req;
    logic        waw_err;
    logic [2:0]  fifo_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    grf_wb_arbiter #(
        .DEPTH        (4),
        .STARVE_LIMIT (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .p_we      (p_we),
        .p_addr    (p_addr),
        .p_data    (p_data),
        .p_pc      (p_pc),
        .l_valid   (l_valid),
        .l_ready   (l_ready),
        .l_addr    (l_addr),
        .l_data    (l_data),
        .l_pc      (l_pc),
        .iss_valid (iss_valid),
        .iss_dst   (iss_dst),
        .we3       (we3),
        .a3        (a3),
        .wd3       (wd3),
        .pc_out    (pc_out),
        .pending   (pending),
        .stall_req (stall_req),
        .waw_err   (waw_err),
        .fifo_cnt  (fifo_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read 1ns later.
    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; p_we = 1'b0; p_addr = '0; p_data = '0; p_pc = '0;
        l_valid = 1'b0; l_addr = '0; l_data = '0; l_pc = '0;
        iss_valid = 1'b0; iss_dst = '0;

        // Reset state, pipeline write masked while held
        p_we = 1'b1; p_addr = 5'd3;
        nxt();
        chk("rst_l_ready", l_ready, 0);
        chk("rst_we3", we3, 0);
        chk("rst_cnt", fifo_cnt, 0);
        chk("rst_pending", pending, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_waw", waw_err, 0);
        p_we = 1'b0; p_addr = '0;
        nxt();
        reset = 1'b1;
        #1;
        chk("rel_l_ready", l_ready, 1);
        chk("idle_we3", we3, 0);
        chk("idle_a3", a3, 0);

        // Issue to r8, then return its result with an idle pipeline
        iss_valid = 1'b1; iss_dst = 5'd8;
        nxt();
        chk("pend8_set", pending, 32'h0000_0100);
        iss_valid = 1'b0;
        l_valid = 1'b1; l_addr = 5'd8; l_data = 32'hDEADBEEF; l_pc = 32'h100;
        #1;
        chk("no_fallthru_we3", we3, 0);
        nxt();
        l_valid = 1'b0;
        #1;
        chk("t2_cnt", fifo_cnt, 1);
        chk("t2_we3", we3, 1);
        chk("t2_a3", a3, 8);
        chk("t2_wd3", wd3, 32'hDEADBEEF);
        chk("t2_pc", pc_out, 32'h100);
        chk("t2_pend_before_pop", pending, 32'h0000_0100);
        nxt();
        chk("t2_pend_after_pop", pending, 0);
        chk("t2_cnt_empty", fifo_cnt, 0);
        chk("t2_we3_idle", we3, 0);

        // Fill four entries while the pipeline owns the port every cycle
        for (int i = 1; i <= 4; i++) begin
            p_we = 1'b1; p_addr = 5'd20; p_data = 32'h1111_0000 + i; p_pc = 32'h200 + i;
            l_valid = 1'b1; l_addr = 5'(i); l_data = 32'hA0 + i; l_pc = 32'h300 + i;
            #1;
            chk("fill_pipe_a3", a3, 20);
            chk("fill_pipe_wd3", wd3, 32'h1111_0000 + i);
            nxt();
            chk("fill_stall", stall_req, (i == 4) ? 1 : 0);
        end
        l_valid = 1'b0;
        #1;
        chk("full_cnt", fifo_cnt, 4);
        chk("full_l_ready", l_ready, 0);
        p_we = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk("drain_we3", we3, 1);
            chk("drain_a3", a3, k);
            chk("drain_wd3", wd3, 32'hA0 + k);
            chk("drain_pc", pc_out, 32'h300 + k);
            nxt();
            if (k == 1) begin
                chk("stall_drop", stall_req, 0);
                chk("drain_l_ready", l_ready, 1);
            end
        end
        chk("drained_cnt", fifo_cnt, 0);
        chk("drained_we3", we3, 0);

        // Issue and pop hitting r5 in the same cycle: the set wins
        iss_valid = 1'b1; iss_dst = 5'd5;
        l_valid = 1'b1; l_addr = 5'd5; l_data = 32'h55; l_pc = 32'h500;
        nxt();
        l_valid = 1'b0;
        chk("t4_pend5", pending, 32'h0000_0020);
        chk("t4_we3_head", we3, 1);
        nxt();
        iss_valid = 1'b0;
        chk("t4_set_wins", pending, 32'h0000_0020);
        chk("t4_cnt", fifo_cnt, 0);

        // Pipeline write to pending r9
        iss_valid = 1'b1; iss_dst = 5'd9;
        nxt();
        iss_valid = 1'b0;
        p_we = 1'b1; p_addr = 5'd9; p_data = 32'hCAFEF00D; p_pc = 32'h900;
        #1;
        chk("waw_we3", we3, 1);
        chk("waw_a3", a3, 9);
        chk("waw_wd3", wd3, 32'hCAFEF00D);
        chk("waw_pre", waw_err, 0);
        nxt();
        p_we = 1'b0;
        chk("waw_pulse", waw_err, 1);
        nxt();
        chk("waw_clear", waw_err, 0);

        // Address 0 passes through on the pipeline path without an error flag
        p_we = 1'b1; p_addr = 5'd0; p_data = 32'h0BAD;
        #1;
        chk("a0_pipe_a3", a3, 0);
        chk("a0_pipe_wd3", wd3, 32'h0BAD);
        nxt();
        p_we = 1'b0;
        chk("a0_pipe_waw", waw_err, 0);

        // Long-latency write to r0 is accepted but dropped
        l_valid = 1'b1; l_addr = 5'd0; l_data = 32'h1234;
        #1;
        chk("a0_l_ready", l_ready, 1);
        nxt();
        l_valid = 1'b0;
        chk("a0_cnt", fifo_cnt, 0);
        chk("a0_we3", we3, 0);

        // Reset with two entries queued behind a busy pipeline
        p_we = 1'b1; p_addr = 5'd21;
        for (int i = 0; i < 2; i++) begin
            iss_valid = 1'b1; iss_dst = 5'(10 + i);
            l_valid = 1'b1; l_addr = 5'(10 + i); l_data = 32'hF0 + i;
            nxt();
        end
        iss_valid = 1'b0; l_valid = 1'b0;
        chk("q2_cnt", fifo_cnt, 2);
        chk("q2_pending", pending, 32'h0000_0E20);
        reset = 1'b0;
        #1;
        chk("mid_rst_cnt", fifo_cnt, 0);
        chk("mid_rst_pending", pending, 0);
        chk("mid_rst_we3", we3, 0);
        chk("mid_rst_l_ready", l_ready, 0);
        p_we = 1'b0;
        nxt();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            nxt();
            chk("post_rst_we3", we3, 0);
        end
        chk("post_rst_cnt", fifo_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
